// File: rtl/plru_alloc_ctrl_if.sv
// Handshake and side-traffic bundle between tag-compare/fill engine and the
// PLRU victim allocation controller.
interface plru_alloc_ctrl_if #(
    parameter int SET_W = 4
) ();
    logic             hit_valid;
    logic [SET_W-1:0] hit_set;
    logic [1:0]       hit_way;
    logic             miss_valid;
    logic             miss_ready;
    logic [SET_W-1:0] miss_set;
    logic             vic_valid;
    logic             vic_ready;
    logic [SET_W-1:0] vic_set;
    logic [1:0]       vic_way;
    logic             inv_valid;
    logic [SET_W-1:0] inv_set;
    logic [1:0]       inv_way;
    logic             flush_req;
    logic             flush_busy;

    modport master (
        output hit_valid, hit_set, hit_way,
        output miss_valid, miss_set,
        input  miss_ready,
        input  vic_valid, vic_set, vic_way,
        output vic_ready,
        output inv_valid, inv_set, inv_way,
        output flush_req,
        input  flush_busy
    );

    modport slave (
        input  hit_valid, hit_set, hit_way,
        input  miss_valid, miss_set,
        output miss_ready,
        output vic_valid, vic_set, vic_way,
        input  vic_ready,
        input  inv_valid, inv_set, inv_way,
        input  flush_req,
        output flush_busy
    );
endinterface

// File: rtl/plru_alloc_ctrl.sv
// Per-set tree-PLRU victim allocator for a 4-way tag array: registered victim
// response over valid/ready, hit touches, invalidates and a sequential flush sweep.
module plru_alloc_ctrl #(
    parameter int NSETS = 16
) (
    input logic              clk,
    input logic              rst_n,
    plru_alloc_ctrl_if.slave bus
);
    localparam int SET_W = $clog2(NSETS);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [2:0]       tree      [NSETS];
    logic [3:0]       valid     [NSETS];
    logic [2:0]       tree_nxt  [NSETS];
    logic [3:0]       valid_nxt [NSETS];
    logic             flush_pending;
    logic [SET_W:0]   sweep_cnt;
    logic [SET_W-1:0] lk_set;
    logic [1:0]       vic_way_q;
    logic [SET_W-1:0] vic_set_q;
    logic [1:0]       victim;
    logic             miss_ready;
    logic             miss_fire;
    logic             alloc_fire;
    logic             sweep_last;

    // Tree bits: [2] root, [1] left pair, [0] right pair; each points at the colder side.
    function automatic logic [2:0] touch(input logic [2:0] t, input logic [1:0] w);
        logic [2:0] r;
        r = t;
        case (w)
            2'd0: begin r[2] = 1'b1; r[1] = 1'b1; end
            2'd1: begin r[2] = 1'b1; r[1] = 1'b0; end
            2'd2: begin r[2] = 1'b0; r[0] = 1'b1; end
            default: begin r[2] = 1'b0; r[0] = 1'b0; end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] pick_victim(input logic [2:0] t, input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else if (!v[3]) return 2'd3;
        else if (!t[2]) return t[1] ? 2'd1 : 2'd0;
        else            return t[0] ? 2'd3 : 2'd2;
    endfunction

    assign miss_ready = (state == IDLE) && !flush_pending && rst_n;
    assign miss_fire  = bus.miss_valid && miss_ready;
    assign alloc_fire = (state == RESP) && bus.vic_ready;
    assign sweep_last = (sweep_cnt == (SET_W+1)'(NSETS-1));

    // Ordering per set: hit touch, then invalidate, then allocation (wins shared bits), then flush clear.
    always_comb begin
        for (int s = 0; s < NSETS; s++) begin
            tree_nxt[s]  = tree[s];
            valid_nxt[s] = valid[s];
            if (bus.hit_valid && (state != FLUSH) && (bus.hit_set == SET_W'(s)))
                tree_nxt[s] = touch(tree_nxt[s], bus.hit_way);
            if (bus.inv_valid && (bus.inv_set == SET_W'(s)))
                valid_nxt[s][bus.inv_way] = 1'b0;
            if (alloc_fire && (vic_set_q == SET_W'(s))) begin
                tree_nxt[s]             = touch(tree_nxt[s], vic_way_q);
                valid_nxt[s][vic_way_q] = 1'b1;
            end
            if ((state == FLUSH) && (sweep_cnt[SET_W-1:0] == SET_W'(s))) begin
                tree_nxt[s]  = 3'b000;
                valid_nxt[s] = 4'b0000;
            end
        end
    end

    assign victim = pick_victim(tree_nxt[lk_set], valid_nxt[lk_set]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_pending)  state_nxt = FLUSH;
                else if (miss_fire) state_nxt = LOOKUP;
            end
            LOOKUP: state_nxt = RESP;
            RESP:   if (bus.vic_ready) state_nxt = IDLE;
            FLUSH:  if (sweep_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NSETS; s++) begin
                tree[s]  <= 3'b000;
                valid[s] <= 4'b0000;
            end
            flush_pending <= 1'b0;
            sweep_cnt     <= '0;
            lk_set        <= '0;
            vic_way_q     <= 2'd0;
            vic_set_q     <= '0;
        end else begin
            for (int s = 0; s < NSETS; s++) begin
                tree[s]  <= tree_nxt[s];
                valid[s] <= valid_nxt[s];
            end
            if ((state == IDLE) && flush_pending)
                flush_pending <= 1'b0;
            else if (bus.flush_req && (state != FLUSH))
                flush_pending <= 1'b1;
            if (state == FLUSH) sweep_cnt <= sweep_cnt + 1'b1;
            else                sweep_cnt <= '0;
            if ((state == IDLE) && !flush_pending && bus.miss_valid)
                lk_set <= bus.miss_set;
            if (state == LOOKUP) begin
                vic_way_q <= victim;
                vic_set_q <= lk_set;
            end
        end
    end

    assign bus.miss_ready = miss_ready;
    assign bus.vic_valid  = (state == RESP);
    assign bus.vic_way    = vic_way_q;
    assign bus.vic_set    = vic_set_q;
    assign bus.flush_busy = (state == FLUSH);
endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// Self-checking bench for plru_alloc_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a recency-based reference model.
module tb_plru_alloc_ctrl;
    localparam int NSETS = 16;
    localparam int SET_W = 4;
    localparam int P_IDLE = 0, P_LOOKUP = 1, P_RESP = 2, P_FLUSH = 3;
    localparam int K_MISS = 0, K_HIT = 1, K_INV = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    plru_alloc_ctrl_if #(.SET_W(SET_W)) bus ();

    plru_alloc_ctrl #(.NSETS(NSETS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: recency per tree node instead of bit encoding.
    bit mvalid [NSETS][4];
    int last_half [NSETS];
    int last_left [NSETS];
    int last_right [NSETS];
    int m_phase, m_cnt, m_lk_set, m_vic_set, m_vic_way;
    bit m_pend;

    function automatic void model_clear_set(int s);
        for (int w = 0; w < 4; w++) mvalid[s][w] = 1'b0;
        last_half[s]  = 1;
        last_left[s]  = 1;
        last_right[s] = 3;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++) model_clear_set(s);
        m_phase = P_IDLE; m_pend = 1'b0; m_cnt = 0;
        m_lk_set = 0; m_vic_set = 0; m_vic_way = 0;
    endfunction

    function automatic void model_touch(int s, int w);
        last_half[s] = w / 2;
        if (w < 2) last_left[s] = w;
        else       last_right[s] = w;
    endfunction

    function automatic int model_victim(int s);
        for (int w = 0; w < 4; w++)
            if (!mvalid[s][w]) return w;
        if (last_half[s] == 1) return 1 - last_left[s];
        return 5 - last_right[s];
    endfunction

    function automatic void model_step();
        int ph;
        bit rdy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ph  = m_phase;
        rdy = (ph == P_IDLE) && !m_pend;
        if (bus.hit_valid && ph != P_FLUSH) model_touch(int'(bus.hit_set), int'(bus.hit_way));
        if (bus.inv_valid) mvalid[bus.inv_set][bus.inv_way] = 1'b0;
        case (ph)
            P_LOOKUP: begin
                m_vic_way = model_victim(m_lk_set);
                m_vic_set = m_lk_set;
                m_phase   = P_RESP;
            end
            P_RESP: if (bus.vic_ready) begin
                model_touch(m_vic_set, m_vic_way);
                mvalid[m_vic_set][m_vic_way] = 1'b1;
                m_phase = P_IDLE;
            end
            P_FLUSH: begin
                model_clear_set(m_cnt);
                m_cnt++;
                if (m_cnt == NSETS) m_phase = P_IDLE;
            end
            default: begin
                if (m_pend) begin
                    m_phase = P_FLUSH;
                    m_cnt   = 0;
                end else if (bus.miss_valid && rdy) begin
                    m_phase  = P_LOOKUP;
                    m_lk_set = int'(bus.miss_set);
                end
            end
        endcase
        if (ph == P_IDLE && m_pend)             m_pend = 1'b0;
        else if (bus.flush_req && ph != P_FLUSH) m_pend = 1'b1;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check_output("m_vic_valid", int'(bus.vic_valid), int'(m_phase == P_RESP));
        if (m_phase == P_RESP) begin
            check_output("m_vic_way", int'(bus.vic_way), m_vic_way);
            check_output("m_vic_set", int'(bus.vic_set), m_vic_set);
        end
        check_output("m_miss_ready", int'(bus.miss_ready),
                     int'(m_phase == P_IDLE && !m_pend && rst_n));
        check_output("m_flush_busy", int'(bus.flush_busy), int'(m_phase == P_FLUSH));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.miss_ready && n < 40) begin
            tick();
            n++;
        end
        check_output("miss_ready_wait", int'(bus.miss_ready), 1);
    endtask

    task automatic do_miss(input int set, input int exp_way, input int stall);
        wait_ready();
        bus.miss_valid = 1'b1;
        bus.miss_set   = SET_W'(set);
        bus.vic_ready  = (stall == 0);
        tick();
        bus.miss_valid = 1'b0;
        check_output("lookup_vic_valid", int'(bus.vic_valid), 0);
        tick();
        check_output("resp_vic_valid", int'(bus.vic_valid), 1);
        check_output("resp_vic_way", int'(bus.vic_way), exp_way);
        check_output("resp_vic_set", int'(bus.vic_set), set);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_output("stall_vic_valid", int'(bus.vic_valid), 1);
            check_output("stall_vic_way", int'(bus.vic_way), exp_way);
            check_output("stall_vic_set", int'(bus.vic_set), set);
            check_output("stall_miss_ready", int'(bus.miss_ready), 0);
        end
        bus.vic_ready = 1'b1;
        tick();
        bus.vic_ready = 1'b0;
        check_output("done_vic_valid", int'(bus.vic_valid), 0);
    endtask

    typedef struct {
        int kind;
        int set;
        int way;
        int exp_way;
    } vec_t;

    task automatic apply_stimulus(input vec_t v);
        case (v.kind)
            K_HIT: begin
                bus.hit_valid = 1'b1; bus.hit_set = SET_W'(v.set); bus.hit_way = 2'(v.way);
                tick();
                bus.hit_valid = 1'b0;
            end
            K_INV: begin
                bus.inv_valid = 1'b1; bus.inv_set = SET_W'(v.set); bus.inv_way = 2'(v.way);
                tick();
                bus.inv_valid = 1'b0;
            end
            default: do_miss(v.set, v.exp_way, 0);
        endcase
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[17];
        int   busy_cycles;

        vecs[0]  = '{K_MISS, 3, 0, 0};
        vecs[1]  = '{K_MISS, 3, 0, 1};
        vecs[2]  = '{K_MISS, 3, 0, 2};
        vecs[3]  = '{K_MISS, 3, 0, 3};
        vecs[4]  = '{K_MISS, 3, 0, 0};
        vecs[5]  = '{K_HIT,  3, 0, 0};
        vecs[6]  = '{K_MISS, 3, 0, 2};
        vecs[7]  = '{K_HIT,  3, 2, 0};
        vecs[8]  = '{K_MISS, 3, 0, 1};
        vecs[9]  = '{K_INV,  3, 2, 0};
        vecs[10] = '{K_MISS, 3, 0, 2};
        vecs[11] = '{K_MISS, 3, 0, 0};
        vecs[12] = '{K_MISS, 3, 0, 3};
        vecs[13] = '{K_MISS, 5, 0, 0};
        vecs[14] = '{K_INV,  3, 0, 0};
        vecs[15] = '{K_MISS, 3, 0, 0};
        vecs[16] = '{K_MISS, 3, 0, 2};

        model_reset();
        rst_n = 1'b0;
        bus.hit_valid = 0; bus.hit_set = 0; bus.hit_way = 0;
        bus.miss_valid = 0; bus.miss_set = 0; bus.vic_ready = 0;
        bus.inv_valid = 0; bus.inv_set = 0; bus.inv_way = 0;
        bus.flush_req = 0;
        repeat (3) tick();
        check_output("rst_vic_valid", int'(bus.vic_valid), 0);
        check_output("rst_vic_way", int'(bus.vic_way), 0);
        check_output("rst_vic_set", int'(bus.vic_set), 0);
        check_output("rst_flush_busy", int'(bus.flush_busy), 0);
        check_output("rst_miss_ready", int'(bus.miss_ready), 0);
        rst_n = 1'b1;
        tick();
        check_output("post_rst_miss_ready", int'(bus.miss_ready), 1);

        for (int i = 0; i < 17; i++) apply_stimulus(vecs[i]);

        // Set 3 is full with the left pair pointing at way1 -> long stall on that victim.
        do_miss(3, 1, 5);

        // Flush requested while a response is held; sweep follows the handshake.
        wait_ready();
        bus.miss_valid = 1'b1; bus.miss_set = 4'd7;
        tick();
        bus.miss_valid = 1'b0;
        tick();
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        check_output("flushreq_resp_busy", int'(bus.flush_busy), 0);
        check_output("flushreq_resp_vic_valid", int'(bus.vic_valid), 1);
        bus.vic_ready = 1'b1;
        tick();
        bus.vic_ready = 1'b0;
        check_output("flush_pending_ready", int'(bus.miss_ready), 0);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            bus.hit_valid = 1'b1;
            bus.hit_set   = SET_W'($urandom_range(0, NSETS - 1));
            bus.hit_way   = 2'($urandom_range(0, 3));
            tick();
            if (bus.flush_busy) busy_cycles++;
        end
        bus.hit_valid = 1'b0;
        check_output("flush_busy_cycles", busy_cycles, NSETS);
        do_miss(3, 0, 0);
        do_miss(7, 0, 0);
        do_miss(3, 1, 0);

        // Reset while a response is outstanding.
        wait_ready();
        bus.miss_valid = 1'b1; bus.miss_set = 4'd3;
        tick();
        bus.miss_valid = 1'b0;
        tick();
        check_output("pre_rst_vic_valid", int'(bus.vic_valid), 1);
        rst_n = 1'b0;
        tick();
        check_output("midrst_vic_valid", int'(bus.vic_valid), 0);
        check_output("midrst_vic_way", int'(bus.vic_way), 0);
        check_output("midrst_miss_ready", int'(bus.miss_ready), 0);
        rst_n = 1'b1;
        tick();
        check_output("midrst_release_ready", int'(bus.miss_ready), 1);
        do_miss(3, 0, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 499) != 0);
            bus.miss_valid = ($urandom_range(0, 9) < 4);
            bus.miss_set   = SET_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NSETS - 1)
                                                                 : $urandom_range(0, 3));
            bus.vic_ready  = ($urandom_range(0, 9) < 6);
            bus.hit_valid  = ($urandom_range(0, 9) < 3);
            bus.hit_set    = SET_W'($urandom_range(0, 3));
            bus.hit_way    = 2'($urandom_range(0, 3));
            bus.inv_valid  = ($urandom_range(0, 9) < 2);
            bus.inv_set    = SET_W'($urandom_range(0, 3));
            bus.inv_way    = 2'($urandom_range(0, 3));
            bus.flush_req  = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
